// File: rtl/viterbi_ber_checker.sv
// -----------------------------------------------------------------------------
// viterbi_ber_checker
//
// Bit-error-rate checker placed after the Viterbi decoder. Message bits that
// fed the convolutional encoder are queued in a reference FIFO; each decoded
// bit pops the oldest reference bit and the two are compared. After start_i,
// the first SKIP decoded bits are discarded (traceback warm-up), then WINDOW
// bits are compared. The counters then freeze and done_o is held.
//
// Parameters
//   DEPTH   reference FIFO depth (power of 2, >= 2, >= decoder latency in bits)
//   SKIP    decoded bits discarded after start_i
//   WINDOW  compared bits per measurement (1 .. 2**CW-1)
//   CW      width of all counters and count outputs
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start_i      1-cycle pulse: flush FIFO, clear counters/flags, start a run
//   ref_valid_i  ref_bit_i strobe (encoder-input side)
//   ref_bit_i    reference message bit
//   dec_valid_i  dec_bit_i strobe (decoder-output side)
//   dec_bit_i    decoded bit
//   busy_o       in SKIP or COUNT
//   done_o       window complete; held until start_i or reset
//   bit_cnt_o    bits compared in COUNT
//   err_cnt_o    mismatches in COUNT (saturating)
//   ovf_o        sticky: push while FIFO full (bit dropped)
//   udf_o        sticky: decoded strobe while FIFO empty
//   max_burst_o  longest run of consecutive mismatches (only with the macro)
//
// Build option
//   VITERBI_BER_BURST_EN  adds max_burst_o and the burst-run tracking logic.
// -----------------------------------------------------------------------------
module viterbi_ber_checker #(
  parameter int DEPTH  = 64,
  parameter int SKIP   = 0,
  parameter int WINDOW = 256,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          ref_valid_i,
  input  logic          ref_bit_i,
  input  logic          dec_valid_i,
  input  logic          dec_bit_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] bit_cnt_o,
  output logic [CW-1:0] err_cnt_o,
`ifdef VITERBI_BER_BURST_EN
  output logic [CW-1:0] max_burst_o,
`endif
  output logic          ovf_o,
  output logic          udf_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] SKIP_LAST = CW'(SKIP - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_COUNT,
    ST_DONE
  } state_t;

  // With no warm-up the run starts directly in COUNT.
  localparam state_t RUN_STATE = (SKIP == 0) ? ST_COUNT : ST_SKIP;

  state_t state, state_nxt;

  // Reference FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic          mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          ref_head;

  logic [CW-1:0] skip_cnt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] err_cnt;
  logic          ovf, udf;

  logic          active;
  logic          push_req, pop_req;
  logic          do_push, do_pop;
  logic          skip_pop, compare, mismatch;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ref_head   = mem[rd_ptr[AW-1:0]];

  assign active   = (state == ST_SKIP) || (state == ST_COUNT);
  // start_i overrides any strobe in the same cycle.
  assign push_req = active && ref_valid_i && !start_i;
  assign pop_req  = active && dec_valid_i && !start_i;
  assign do_pop   = pop_req && !fifo_empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push  = push_req && (!fifo_full || do_pop);
  assign skip_pop = do_pop && (state == ST_SKIP);
  assign compare  = do_pop && (state == ST_COUNT);
  assign mismatch = compare && (dec_bit_i != ref_head);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: the default comes first so every path assigns state_nxt and no
    // latch is inferred.
    state_nxt = state;
    if (start_i) begin
      state_nxt = RUN_STATE;
    end else begin
      case (state)
        ST_SKIP:  if (skip_pop && skip_cnt == SKIP_LAST) state_nxt = ST_COUNT;
        ST_COUNT: if (compare && bit_cnt == WIN_LAST)    state_nxt = ST_DONE;
        default:  ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is not reset; the pointers alone define which
  // entries are valid, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= ref_bit_i;
  end

  // ---------------------------------------------------------------------------
  // Pointers, counters and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skip_cnt <= '0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (start_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      skip_cnt <= '0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (do_push)  wr_ptr   <= wr_ptr + PTR_ONE;
      if (do_pop)   rd_ptr   <= rd_ptr + PTR_ONE;
      if (skip_pop) skip_cnt <= skip_cnt + CNT_ONE;
      if (compare)  bit_cnt  <= bit_cnt + CNT_ONE;
      if (mismatch && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
      if (push_req && fifo_full && !do_pop) ovf <= 1'b1;
      if (pop_req && fifo_empty)            udf <= 1'b1;
    end
  end

`ifdef VITERBI_BER_BURST_EN
  // ---------------------------------------------------------------------------
  // Longest burst of consecutive mismatches
  // ---------------------------------------------------------------------------
  logic [CW-1:0] run_cnt, run_inc, max_burst;

  assign run_inc = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt   <= '0;
      max_burst <= '0;
    end else if (start_i) begin
      run_cnt   <= '0;
      max_burst <= '0;
    end else if (compare) begin
      if (mismatch) begin
        run_cnt <= run_inc;
        if (run_inc > max_burst) max_burst <= run_inc;
      end else begin
        run_cnt <= '0;
      end
    end
  end

  assign max_burst_o = max_burst;
`endif

  assign busy_o    = active;
  assign done_o    = (state == ST_DONE);
  assign bit_cnt_o = bit_cnt;
  assign err_cnt_o = err_cnt;
  assign ovf_o     = ovf;
  assign udf_o     = udf;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// -----------------------------------------------------------------------------
// tb_viterbi_ber_checker
//
// Two checkers share one stimulus stream: dut0 with no warm-up and dut1 with
// an 8-bit warm-up. Single-cycle corner cases come from a vector table; the
// loopback, burst, warm-up, overflow and reset scenarios are hand-written
// sequences. All tasks start at a falling edge, drive inputs, wait for the next
// falling edge, and leave the outputs ready to be read.
// -----------------------------------------------------------------------------
module tb_viterbi_ber_checker;

  localparam int CW    = 16;
  localparam int NREF  = 300;
  localparam int DELAY = 20;

  logic clk = 1'b0;
  logic rst;
  logic start_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i;

  logic          busy0, done0, ovf0, udf0;
  logic [CW-1:0] bit0, err0, burst0;
  logic          busy1, done1, ovf1, udf1;
  logic [CW-1:0] bit1, err1, burst1;

  always #5 clk = ~clk;

  viterbi_ber_checker #(.DEPTH(64), .SKIP(0), .WINDOW(256), .CW(CW)) dut0 (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .ref_valid_i (ref_valid_i),
    .ref_bit_i   (ref_bit_i),
    .dec_valid_i (dec_valid_i),
    .dec_bit_i   (dec_bit_i),
    .busy_o      (busy0),
    .done_o      (done0),
    .bit_cnt_o   (bit0),
    .err_cnt_o   (err0),
`ifdef VITERBI_BER_BURST_EN
    .max_burst_o (burst0),
`endif
    .ovf_o       (ovf0),
    .udf_o       (udf0)
  );

  viterbi_ber_checker #(.DEPTH(64), .SKIP(8), .WINDOW(256), .CW(CW)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .ref_valid_i (ref_valid_i),
    .ref_bit_i   (ref_bit_i),
    .dec_valid_i (dec_valid_i),
    .dec_bit_i   (dec_bit_i),
    .busy_o      (busy1),
    .done_o      (done1),
    .bit_cnt_o   (bit1),
    .err_cnt_o   (err1),
`ifdef VITERBI_BER_BURST_EN
    .max_burst_o (burst1),
`endif
    .ovf_o       (ovf1),
    .udf_o       (udf1)
  );

`ifndef VITERBI_BER_BURST_EN
  assign burst0 = '0;
  assign burst1 = '0;
`endif

  int checks = 0;
  int errors = 0;

  logic refs [NREF];

  typedef struct {
    logic start, rv, rb, dv, db;
    int   bc, ec;
    logic ovf, udf, busy, done;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, rv, rb, dv, db, input int bc, ec,
                              input logic ovf, udf, busy, done);
    vec_t v;
    v.start = s;  v.rv = rv;   v.rb = rb;     v.dv = dv;     v.db = db;
    v.bc    = bc; v.ec = ec;   v.ovf = ovf;   v.udf = udf;
    v.busy  = busy; v.done = done;
    return v;
  endfunction

  task automatic cyc(input logic s, rv, rb, dv, db);
    start_i = s; ref_valid_i = rv; ref_bit_i = rb;
    dec_valid_i = dv; dec_bit_i = db;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start_i = 0; ref_valid_i = 0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0;
  endtask

  task automatic pulse_start();
    cyc(1, 0, 0, 0, 0);
    idle_inputs();
  endtask

  // Refs stream out one per cycle; decoded bits follow DELAY cycles later.
  // Decoded bit k is inverted when k falls in [a_lo,a_hi] or [b_lo,b_hi].
  // done_t* is the first loop index at which each done_o is seen high.
  task automatic run_stream(input int n_cyc, input int a_lo, a_hi, b_lo, b_hi,
                            output int done_t0, output int done_t1);
    done_t0 = -1;
    done_t1 = -1;
    for (int t = 0; t < n_cyc; t++) begin
      int  k;
      logic inv;
      if (done0 && done_t0 < 0) done_t0 = t;
      if (done1 && done_t1 < 0) done_t1 = t;
      k   = t - DELAY;
      inv = (k >= a_lo && k <= a_hi) || (k >= b_lo && k <= b_hi);
      start_i     = 0;
      ref_valid_i = (t < NREF);
      ref_bit_i   = (t < NREF) ? refs[t] : 1'b0;
      dec_valid_i = (k >= 0 && k < NREF);
      dec_bit_i   = (k >= 0 && k < NREF) ? (refs[k] ^ inv) : 1'b0;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy0"},  busy0, 0);
    check({tag, "_done0"},  done0, 0);
    check({tag, "_bit0"},   bit0,  0);
    check({tag, "_err0"},   err0,  0);
    check({tag, "_ovf0"},   ovf0,  0);
    check({tag, "_udf0"},   udf0,  0);
    check({tag, "_burst0"}, burst0, 0);
    check({tag, "_busy1"},  busy1, 0);
    check({tag, "_bit1"},   bit1,  0);
  endtask

  task automatic loopback_checks(input string tag, input int d0);
    check({tag, "_done_cycle"}, d0, DELAY + 256);
    check({tag, "_done0"},      done0, 1);
    check({tag, "_busy0"},      busy0, 0);
    check({tag, "_bit0"},       bit0,  256);
    check({tag, "_err0"},       err0,  0);
    check({tag, "_ovf0"},       ovf0,  0);
    check({tag, "_udf0"},       udf0,  0);
    check({tag, "_burst0"},     burst0, 0);
  endtask

  initial begin
    int d0, d1;

    for (int i = 0; i < NREF; i++) refs[i] = 1'($urandom_range(0, 1));

    //             s  rv rb dv db  bc ec ovf udf busy done
    tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // idle
    tbl[1]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);  // dec strobe ignored in IDLE
    tbl[2]  = mk(0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);  // push ignored in IDLE
    tbl[3]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);  // start -> COUNT
    tbl[4]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 0);  // pop on empty -> udf
    tbl[5]  = mk(0, 1, 1, 1, 1,  0, 0, 0, 1, 1, 0);  // push+pop on empty: push lands
    tbl[6]  = mk(0, 0, 0, 1, 1,  1, 0, 0, 1, 1, 0);  // match
    tbl[7]  = mk(0, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0);  // push 0
    tbl[8]  = mk(0, 0, 0, 1, 1,  2, 1, 0, 1, 1, 0);  // mismatch
    tbl[9]  = mk(0, 1, 1, 1, 0,  2, 1, 0, 1, 1, 0);  // empty again: push lands, no count
    tbl[10] = mk(1, 1, 0, 1, 0,  0, 0, 0, 0, 1, 0);  // start wins, clears all
    tbl[11] = mk(0, 0, 0, 1, 1,  0, 0, 0, 1, 1, 0);  // FIFO was flushed -> udf

    // Reset state
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].start, tbl[i].rv, tbl[i].rb, tbl[i].dv, tbl[i].db);
      check($sformatf("tbl%0d_bit", i),  bit0,  tbl[i].bc);
      check($sformatf("tbl%0d_err", i),  err0,  tbl[i].ec);
      check($sformatf("tbl%0d_ovf", i),  ovf0,  tbl[i].ovf);
      check($sformatf("tbl%0d_udf", i),  udf0,  tbl[i].udf);
      check($sformatf("tbl%0d_busy", i), busy0, tbl[i].busy);
      check($sformatf("tbl%0d_done", i), done0, tbl[i].done);
    end
    idle_inputs();

    // Loopback, decoded = refs delayed, no errors; inputs keep flowing after
    // done so the frozen counters are checked too.
    pulse_start();
    run_stream(320, -1, -2, -1, -2, d0, d1);
    loopback_checks("loop", d0);

    // Bursts of 4 then 2 mismatches
    pulse_start();
    check("burst_done_cleared", done0, 0);
    run_stream(320, 10, 13, 100, 101, d0, d1);
    check("burst_bit0", bit0, 256);
    check("burst_err0", err0, 6);
`ifdef VITERBI_BER_BURST_EN
    check("burst_max0", burst0, 4);
`endif

    // Warm-up: first 8 decoded bits wrong; dut1 discards them, dut0 counts them
    pulse_start();
    run_stream(320, 0, 7, -1, -2, d0, d1);
    check("warm_done_cycle1", d1, DELAY + 8 + 256);
    check("warm_bit1", bit1, 256);
    check("warm_err1", err1, 0);
    check("warm_done1", done1, 1);
    check("warm_ovf1", ovf1, 0);
    check("warm_udf1", udf1, 0);
    check("warm_err0", err0, 8);
`ifdef VITERBI_BER_BURST_EN
    check("warm_max0", burst0, 8);
`endif

    // Overflow: 64 pushes fill the FIFO, the 65th is dropped
    pulse_start();
    for (int i = 0; i < 64; i++) cyc(0, 1, refs[i], 0, 0);
    check("ovf_full_no_flag", ovf0, 0);
    cyc(0, 1, refs[64], 0, 0);
    check("ovf_flag", ovf0, 1);
    for (int i = 0; i < 64; i++) cyc(0, 0, 0, 1, refs[i]);
    check("ovf_drain_bit", bit0, 64);
    check("ovf_drain_err", err0, 0);
    check("ovf_drain_udf", udf0, 0);
    cyc(0, 0, 0, 1, 0);
    check("ovf_dropped_udf", udf0, 1);
    check("ovf_dropped_bit", bit0, 64);
    idle_inputs();

    // Full FIFO with simultaneous push and pop is legal
    pulse_start();
    for (int i = 0; i < 64; i++) cyc(0, 1, refs[i], 0, 0);
    cyc(0, 1, refs[64], 1, refs[0]);
    check("full_pp_ovf", ovf0, 0);
    check("full_pp_bit", bit0, 1);
    for (int i = 1; i <= 64; i++) cyc(0, 0, 0, 1, refs[i]);
    check("full_pp_drain_bit", bit0, 65);
    check("full_pp_drain_err", err0, 0);
    check("full_pp_drain_udf", udf0, 0);
    cyc(0, 0, 0, 1, 0);
    check("full_pp_empty_udf", udf0, 1);
    idle_inputs();

    // Reset in the middle of COUNT, then a clean run
    pulse_start();
    run_stream(DELAY + 100, -1, -2, -1, -2, d0, d1);
    check("mid_bit0", bit0, 100);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");
    pulse_start();
    run_stream(320, -1, -2, -1, -2, d0, d1);
    loopback_checks("rerun", d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
